regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32×32 integer register file among NUM_REQ writeback requesters (ALU, load/store unit, mul/div) using round-robin arbitration. It also keeps a busy scoreboard of destinations with in-flight results and stalls issue on RAW/WAW hazards. It sits between the execution units and the register file, and drives its regWrite/rd/writeData inputs from a registered output stage.

---
 rtl/rv_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared integer-pipeline constants: datapath widths and writeback requester indices.
package rv_pkg;
    localparam int XLEN          = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin arbiter; priority starts just after the last granted index,
// and the pointer moves only when a grant is issued.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gnt_idx;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;

    // Requests above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            mask[i] = (PW'(i) > ptr);
    end

    assign masked = req & mask;
    assign gnt    = (|masked) ? (masked & (~masked + NUM_REQ'(1)))
                              : (req & (~req + NUM_REQ'(1)));

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) gnt_idx = gnt_idx | PW'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= PW'(NUM_REQ - 1);
        else if (|gnt)
            ptr <= gnt_idx;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port plus a busy scoreboard
// that stalls issue on RAW/WAW hazards against in-flight results.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = rv_pkg::XLEN,
    parameter int REG_ADDR_W = rv_pkg::REG_ADDR_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_rd,
    input  logic [NUM_REQ-1:0][XLEN-1:0]         req_data,
    input  logic                                 issue_valid,
    input  logic [REG_ADDR_W-1:0]                issue_rd,
    input  logic [REG_ADDR_W-1:0]                issue_rs1,
    input  logic [REG_ADDR_W-1:0]                issue_rs2,
    output logic                                 issue_stall,
    output logic                                 regWrite,
    output logic [REG_ADDR_W-1:0]                rd,
    output logic [XLEN-1:0]                      writeData,
    output logic [rv_pkg::NUM_ARCH_REGS-1:0]     busy,
    output logic                                 wb_err
);
    import rv_pkg::*;

    logic [NUM_REQ-1:0]       gnt;
    logic [REG_ADDR_W-1:0]    sel_rd;
    logic [XLEN-1:0]          sel_data;
    logic [NUM_ARCH_REGS-1:0] busy_nxt;
    logic                     reserve;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    // Grant is a subset of valid, so every grant is a completed handshake.
    assign req_ready = gnt;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = sel_rd | req_rd[i];
                sel_data = sel_data | req_data[i];
            end
        end
    end

    assign issue_stall = issue_valid &&
                         ((busy[issue_rs1] && issue_rs1 != '0) ||
                          (busy[issue_rs2] && issue_rs2 != '0) ||
                          (busy[issue_rd]  && issue_rd  != '0));

    assign reserve = issue_valid && !issue_stall && issue_rd != '0;

    // Clear and reserve never hit the same index: a busy destination stalls issue.
    always_comb begin
        busy_nxt = busy;
        if (regWrite) busy_nxt[rd] = 1'b0;
        if (reserve)  busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWrite  <= 1'b0;
            rd        <= '0;
            writeData <= '0;
            busy      <= '0;
            wb_err    <= 1'b0;
        end else begin
            if (|gnt) begin
                regWrite  <= (sel_rd != '0);
                rd        <= sel_rd;
                writeData <= sel_data;
            end else begin
                regWrite  <= 1'b0;
            end
            busy <= busy_nxt;
            if (regWrite && rd != '0 && !busy[rd])
                wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed hazard/arbitration scenarios followed by randomized traffic, all
// checked cycle by cycle against a queue-free behavioural model of the rules.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N-1:0][AW-1:0]    req_rd;
    logic [N-1:0][DW-1:0]    req_data;
    logic                    issue_valid;
    logic [AW-1:0]           issue_rd, issue_rs1, issue_rs2;
    logic                    issue_stall;
    logic                    regWrite;
    logic [AW-1:0]           rd;
    logic [DW-1:0]           writeData;
    logic [31:0]             busy;
    logic                    wb_err;

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(DW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_stall(issue_stall),
        .regWrite(regWrite), .rd(rd), .writeData(writeData),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Register file as seen from the DUT's write port.
    logic [31:0] rf [32];
    always @(posedge clk) if (regWrite && rd != 0) rf[rd] <= writeData;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [31:0] m_busy;
    bit        m_rw;
    bit [4:0]  m_rd;
    bit [31:0] m_wd;
    bit        m_err;
    int        m_last;
    int        gidx;
    logic [N-1:0] last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g = '0;
        for (int k = 1; k <= N; k++) begin
            int idx = (m_last + k) % N;
            if (g == '0 && req_valid[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic bit exp_stall();
        return issue_valid && ((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                               (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                               (issue_rd  != 0 && m_busy[issue_rd]));
    endfunction

    task automatic model_reset();
        m_busy = '0; m_rw = 0; m_rd = '0; m_wd = '0; m_err = 0; m_last = N - 1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_rd = '0; req_data = '0;
        issue_valid = 0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic [N-1:0] eg;
        bit es;
        #1;
        eg = exp_gnt();
        es = exp_stall();
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(eg));
        chk("issue_stall", 64'(issue_stall), 64'(es));
        gidx = -1;
        for (int i = 0; i < N; i++) if (eg[i]) gidx = i;
        @(posedge clk);
        if (m_rw) begin
            if (m_rd != 0 && !m_busy[m_rd]) m_err = 1;
            m_busy[m_rd] = 0;
        end
        if (issue_valid && !es && issue_rd != 0) m_busy[issue_rd] = 1;
        if (gidx >= 0) begin
            m_rw = (req_rd[gidx] != 0);
            m_rd = req_rd[gidx];
            m_wd = req_data[gidx];
            m_last = gidx;
        end else begin
            m_rw = 0;
        end
        #1;
        chk("regWrite", 64'(regWrite), 64'(m_rw));
        chk("rd", 64'(rd), 64'(m_rd));
        chk("writeData", 64'(writeData), 64'(m_wd));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        issue_valid = 1; issue_rd = d; issue_rs1 = s1; issue_rs2 = s2;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        gidx = -1;
        rst = 0;
        repeat (2) @(negedge clk);
        chk("rst_regWrite", 64'(regWrite), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        rst = 1;
        @(negedge clk);

        // Round-robin: reserve x1..x3, then three requesters continuously valid.
        for (int r = 1; r <= 3; r++) begin
            do_issue(5'(r), 5'd0, 5'd0);
            step();
        end
        issue_valid = 0;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            req_rd[i] = 5'(i + 1);
            req_data[i] = 32'hA000_0000 + 32'(i);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rr_grant", 64'(last_ready), 64'(1 << (c % 3)));
            chk("rr_wr_rd", 64'(rd), 64'(c % 3 + 1));
        end

        // Asynchronous reset in the middle of a cycle with a write in flight.
        #2 rst = 0;
        #1;
        chk("arst_regWrite", 64'(regWrite), 64'd0);
        chk("arst_rd", 64'(rd), 64'd0);
        chk("arst_wdata", 64'(writeData), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_wb_err", 64'(wb_err), 64'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst = 1;

        // After reset requester 0 has priority over requester 1.
        req_valid = 3'b011;
        step();
        chk("first_grant", 64'(last_ready), 64'b001);
        req_valid[0] = 0;
        step();
        chk("second_grant", 64'(last_ready), 64'b010);
        idle_inputs();

        // RAW on x5
        do_issue(5'd5, 5'd0, 5'd0);
        step();
        chk("raw_busy5", 64'(busy[5]), 64'd1);
        do_issue(5'd0, 5'd5, 5'd0);
        req_valid[1] = 1; req_rd[1] = 5'd5; req_data[1] = 32'hDEADBEEF;
        step();
        chk("raw_stall_N", 64'(last_ready), 64'b010);
        chk("raw_wr", 64'({regWrite, rd}), 64'({1'b1, 5'd5}));
        req_valid[1] = 0;
        #1 chk("raw_stall_N1", 64'(issue_stall), 64'd1);
        step();
        #1 chk("raw_stall_N2", 64'(issue_stall), 64'd0);
        chk("raw_rf5", 64'(rf[5]), 64'hDEADBEEF);
        step();

        // WAW on x7
        do_issue(5'd7, 5'd0, 5'd0);
        step();
        #1 chk("waw_stall", 64'(issue_stall), 64'd1);
        req_valid[0] = 1; req_rd[0] = 5'd7; req_data[0] = 32'h0000_0777;
        step();
        req_valid[0] = 0;
        step();
        #1 chk("waw_release", 64'(issue_stall), 64'd0);
        step();
        chk("waw_rebusy", 64'(busy[7]), 64'd1);
        idle_inputs();

        // x0: no reservation, no stall; write to x0 accepted silently.
        do_issue(5'd0, 5'd0, 5'd0);
        req_valid[1] = 1; req_rd[1] = 5'd0; req_data[1] = 32'h1111_1111;
        step();
        chk("x0_ready", 64'(last_ready), 64'b010);
        chk("x0_busy0", 64'(busy[0]), 64'd0);
        chk("x0_regWrite", 64'(regWrite), 64'd0);
        idle_inputs();
        step();
        chk("x0_wb_err", 64'(wb_err), 64'd0);

        // Write to non-busy x9 raises sticky wb_err.
        req_valid[2] = 1; req_rd[2] = 5'd9; req_data[2] = 32'h0000_1234;
        step();
        chk("err_wr", 64'({regWrite, rd}), 64'({1'b1, 5'd9}));
        chk("err_before", 64'(wb_err), 64'd0);
        req_valid[2] = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("err_sticky", 64'(wb_err), 64'd1);
        end

        // Randomized traffic; requesters hold until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (gidx == i) req_valid[i] = 0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1;
                    req_rd[i]    = 5'($urandom_range(0, 7));
                    req_data[i]  = $urandom;
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
